secuenciador_programable: RTL and testbench

SECUENCIADOR_PROGRAMABLE -- requirements
Module: secuenciador_programable

---
 rtl/secuenciador_programable.sv | 90 +++++++++
 tb/tb_secuenciador_programable.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/secuenciador_programable.sv
// Programmable sequencer: an N-entry table of W-bit states walked forward or
// backward. The index can be loaded directly, and table entries can be rewritten at run time.
module secuenciador_programable #(
  parameter int W = 4,
  parameter int N = 10,
  localparam int IW = (N < 2) ? 1 : $clog2(N)
) (
  input  logic          C,
  input  logic          R,
  input  logic          en,
  input  logic          dir,
  input  logic          ld,
  input  logic [IW-1:0] ld_idx,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  output logic [W-1:0]  Q,
  output logic [IW-1:0] idx,
  output logic          wrap,
  output logic          err
);

  localparam logic [IW-1:0] LAST = IW'(N - 1);

  logic [W-1:0]  r_table [N];
  logic [IW-1:0] r_idx;
  logic          r_wrap;
  logic          r_err;

  logic          w_ldOk;
  logic          w_wrOk;
  logic [IW-1:0] w_idxNext;
  logic          w_wrapNext;

  // Position update: load beats stepping, and a bad load index blocks the step.
  always_comb begin
    w_ldOk     = (ld_idx <= LAST);
    w_wrOk     = (wr_addr <= LAST);
    w_idxNext  = r_idx;
    w_wrapNext = 1'b0;
    if (ld) begin
      if (w_ldOk) begin
        w_idxNext = ld_idx;
      end
    end else if (en) begin
      if (!dir) begin
        if (r_idx == LAST) begin
          w_idxNext  = '0;
          w_wrapNext = 1'b1;
        end else begin
          w_idxNext = r_idx + 1'b1;
        end
      end else begin
        if (r_idx == '0) begin
          w_idxNext  = LAST;
          w_wrapNext = 1'b1;
        end else begin
          w_idxNext = r_idx - 1'b1;
        end
      end
    end
  end

  // Reset restores the identity table; table writes are independent of stepping.
  always_ff @(posedge C) begin
    if (R) begin
      r_idx  <= '0;
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_table[i] <= W'(i);
      end
    end else begin
      r_idx  <= w_idxNext;
      r_wrap <= w_wrapNext;
      if ((ld && !w_ldOk) || (wr_en && !w_wrOk)) begin
        r_err <= 1'b1;
      end
      if (wr_en && w_wrOk) begin
        r_table[wr_addr] <= wr_data;
      end
    end
  end

  assign Q    = r_table[r_idx];
  assign idx  = r_idx;
  assign wrap = r_wrap;
  assign err  = r_err;

endmodule

// File: tb/tb_secuenciador_programable.sv
// Directed bench for the programmable sequencer; the main instance uses the default N=10,
// and two extra instances (N=2, N=16) exercise wrap periods.
module tb_secuenciador_programable;

  logic       C;
  logic       R;
  logic       en, dir, ld, wr_en;
  logic [3:0] ldIdx, wrAddr, wrData;
  logic [3:0] q;
  logic [3:0] idx;
  logic       wrap, err;

  logic       en2;
  logic [0:0] zero1;
  logic [3:0] q2;
  logic [0:0] idx2;
  logic       wrap2, err2;

  logic       en16;
  logic [3:0] zero4;
  logic [3:0] q16, idx16;
  logic       wrap16, err16;

  int checks = 0;
  int errors = 0;

  logic [3:0] seqTable [10];

  secuenciador_programable #(.W(4), .N(10)) dut (
    .C(C), .R(R), .en(en), .dir(dir), .ld(ld), .ld_idx(ldIdx),
    .wr_en(wr_en), .wr_addr(wrAddr), .wr_data(wrData),
    .Q(q), .idx(idx), .wrap(wrap), .err(err)
  );

  secuenciador_programable #(.W(4), .N(2)) dut2 (
    .C(C), .R(R), .en(en2), .dir(1'b0), .ld(1'b0), .ld_idx(zero1),
    .wr_en(1'b0), .wr_addr(zero1), .wr_data(zero4),
    .Q(q2), .idx(idx2), .wrap(wrap2), .err(err2)
  );

  secuenciador_programable #(.W(4), .N(16)) dut16 (
    .C(C), .R(R), .en(en16), .dir(1'b0), .ld(1'b0), .ld_idx(zero4),
    .wr_en(1'b0), .wr_addr(zero4), .wr_data(zero4),
    .Q(q16), .idx(idx16), .wrap(wrap16), .err(err16)
  );

  initial begin
    C = 1'b0;
    forever #5 C = ~C;
  end

  task automatic applyStimulus();
    @(posedge C);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    seqTable = '{4'd3, 4'd1, 4'd4, 4'd1, 4'd5, 4'd9, 4'd2, 4'd6, 4'd5, 4'd3};
    zero1 = '0; zero4 = '0;
    R = 1'b1; en = 0; dir = 0; ld = 0; wr_en = 0;
    ldIdx = 0; wrAddr = 0; wrData = 0; en2 = 0; en16 = 0;

    applyStimulus();
    R = 1'b0;
    checkOutput("rst_idx", 32'(idx), 0);
    checkOutput("rst_q", 32'(q), 0);
    checkOutput("rst_wrap", 32'(wrap), 0);
    checkOutput("rst_err", 32'(err), 0);

    $display("[TB] forward stepping");
    en = 1; dir = 0;
    for (int k = 1; k <= 12; k++) begin
      applyStimulus();
      checkOutput($sformatf("fwd_idx_%0d", k), 32'(idx), k % 10);
      checkOutput($sformatf("fwd_q_%0d", k), 32'(q), k % 10);
      checkOutput($sformatf("fwd_wrap_%0d", k), 32'(wrap), (k == 10) ? 1 : 0);
    end
    en = 0; dir = 1;
    applyStimulus();
    checkOutput("hold_idx", 32'(idx), 2);
    checkOutput("hold_wrap", 32'(wrap), 0);

    $display("[TB] backward stepping over custom table");
    R = 1; applyStimulus(); R = 0;
    wr_en = 1;
    for (int i = 0; i < 10; i++) begin
      wrAddr = 4'(i); wrData = seqTable[i];
      applyStimulus();
    end
    wr_en = 0;
    checkOutput("bwd_q0", 32'(q), 3);
    en = 1; dir = 1;
    for (int k = 1; k <= 10; k++) begin
      applyStimulus();
      checkOutput($sformatf("bwd_idx_%0d", k), 32'(idx), 10 - k);
      checkOutput($sformatf("bwd_q_%0d", k), 32'(q), 32'(seqTable[10 - k]));
      checkOutput($sformatf("bwd_wrap_%0d", k), 32'(wrap), (k == 1) ? 1 : 0);
    end

    $display("[TB] load priority and bad load");
    dir = 0; ld = 1; ldIdx = 7;
    applyStimulus();
    checkOutput("ld_idx", 32'(idx), 7);
    checkOutput("ld_q", 32'(q), 6);
    checkOutput("ld_wrap", 32'(wrap), 0);
    ldIdx = 12;
    applyStimulus();
    checkOutput("badld_idx", 32'(idx), 7);
    checkOutput("badld_err", 32'(err), 1);
    ld = 0;
    applyStimulus();
    checkOutput("err_nonblock_idx", 32'(idx), 8);
    checkOutput("err_sticky", 32'(err), 1);
    en = 0;

    $display("[TB] write during step");
    R = 1; applyStimulus(); R = 0;
    ld = 1; ldIdx = 4;
    applyStimulus();
    ld = 0;
    checkOutput("wr_pre_idx", 32'(idx), 4);
    en = 1; dir = 0; wr_en = 1; wrAddr = 5; wrData = 4'hA;
    applyStimulus();
    checkOutput("wr_idx", 32'(idx), 5);
    checkOutput("wr_q", 32'(q), 32'hA);
    checkOutput("wr_err", 32'(err), 0);
    en = 0; wrAddr = 15; wrData = 4'h7;
    applyStimulus();
    wr_en = 0;
    checkOutput("badwr_err", 32'(err), 1);
    checkOutput("badwr_q", 32'(q), 32'hA);

    $display("[TB] reset overrides load and write");
    ld = 1; ldIdx = 6;
    applyStimulus();
    checkOutput("prerst_idx", 32'(idx), 6);
    R = 1; ld = 1; ldIdx = 3; wr_en = 1; wrAddr = 0; wrData = 4'hF; en = 1;
    applyStimulus();
    R = 0; ld = 0; wr_en = 0; en = 0;
    checkOutput("midrst_idx", 32'(idx), 0);
    checkOutput("midrst_q", 32'(q), 0);
    checkOutput("midrst_wrap", 32'(wrap), 0);
    checkOutput("midrst_err", 32'(err), 0);
    ld = 1; ldIdx = 5;
    applyStimulus();
    ld = 0;
    checkOutput("ident_q5", 32'(q), 5);

    $display("[TB] N=2 and N=16 wrap periods");
    checkOutput("n2_start", 32'(idx2), 0);
    checkOutput("n16_start", 32'(idx16), 0);
    en2 = 1; en16 = 1;
    for (int k = 1; k <= 32; k++) begin
      applyStimulus();
      checkOutput($sformatf("n2_idx_%0d", k), 32'(idx2), k % 2);
      checkOutput($sformatf("n2_wrap_%0d", k), 32'(wrap2), (k % 2 == 0) ? 1 : 0);
      checkOutput($sformatf("n16_idx_%0d", k), 32'(idx16), k % 16);
      checkOutput($sformatf("n16_q_%0d", k), 32'(q16), k % 16);
      checkOutput($sformatf("n16_wrap_%0d", k), 32'(wrap16), (k % 16 == 0) ? 1 : 0);
    end
    en2 = 0; en16 = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
